// File: rtl/niu_sio_rcv_pkg.sv
// Shared types and constants for the NIU SIO response receive path.
// Provides the FIFO entry layout, the receive FSM states and the per-lane parity check.
package niu_sio_rcv_pkg;

    localparam int BEATS     = 4;
    localparam int BEAT_W    = 128;
    localparam int PAR_LANES = 8;
    localparam int LANE_W    = BEAT_W / PAR_LANES;
    localparam int PERR_W    = BEATS + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } rcv_state_t;

    typedef struct packed {
        logic [BEAT_W-1:0]       hdr;
        logic [BEATS*BEAT_W-1:0] data;
        logic                    has_data;
        logic [PERR_W-1:0]       perr;
    } rsp_entry_t;

    // Even parity per 16-bit lane; any failing lane flags the whole beat.
    function automatic logic beat_par_err(input logic [BEAT_W-1:0]    data,
                                          input logic [PAR_LANES-1:0] parity);
        logic err;
        err = 1'b0;
        for (int i = 0; i < PAR_LANES; i++) begin
            err |= ((^data[i*LANE_W +: LANE_W]) != parity[i]);
        end
        return err;
    endfunction

endpackage

// File: rtl/niu_sio_rsp_fifo.sv
// Small response FIFO with the head entry presented directly from storage registers.
// A pop in the same cycle as a push on a full FIFO frees the slot the push needs.
module niu_sio_rsp_fifo
    import niu_sio_rcv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       iol2clk,
    input  logic       rst_l,
    input  logic       push,
    input  rsp_entry_t push_entry,
    input  logic       pop,
    output rsp_entry_t head,
    output logic       vld,
    output logic       full,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);

    rsp_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign vld     = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & vld;
    assign do_push = push & (~full | do_pop);
    assign ovf     = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            // NOTE: storage is reset because the head drives the outputs directly and must read as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/niu_sio_rsp_rcv.sv
// SIO->NIU response receiver: header/payload capture, parity check, response queue.
// Define NIU_SIO_RCV_PAR_CHK_EN to build the per-lane parity checker; otherwise rsp_perr is 0.
module niu_sio_rsp_rcv
    import niu_sio_rcv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    iol2clk,
    input  logic                    rst_l,
    input  logic                    sio_niu_hdr_vld,
    input  logic                    sio_niu_datareq,
    input  logic [BEAT_W-1:0]       sio_niu_data,
    input  logic [PAR_LANES-1:0]    sio_niu_parity,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [BEAT_W-1:0]       rsp_hdr,
    output logic [BEATS*BEAT_W-1:0] rsp_data,
    output logic                    rsp_has_data,
    output logic [PERR_W-1:0]       rsp_perr,
    output logic                    ovf_err,
    output logic                    proto_err
);

    rcv_state_t              state_q, state_d;
    logic [1:0]              beat_cnt_q;
    logic [BEAT_W-1:0]       hdr_q;
    logic                    hdr_perr_q;
    logic [3*BEAT_W-1:0]     data_q;
    logic [2:0]              beat_perr_q;
    logic                    par_err;
    logic                    push;
    logic                    proto_set;
    logic                    fifo_ovf;
    logic                    fifo_full;
    rsp_entry_t              push_entry;
    rsp_entry_t              head;

`ifdef NIU_SIO_RCV_PAR_CHK_EN
    assign par_err = beat_par_err(sio_niu_data, sio_niu_parity);
`else
    logic [PAR_LANES-1:0] unused_parity;
    assign unused_parity = sio_niu_parity;
    assign par_err       = 1'b0;
`endif

    // A header is honoured in either state; arriving mid-payload abandons the partial packet.
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        proto_set  = 1'b0;
        push_entry = '0;
        if (sio_niu_hdr_vld) begin
            proto_set = (state_q == PAYLOAD);
            if (sio_niu_datareq) begin
                state_d = PAYLOAD;
            end else begin
                state_d         = IDLE;
                push            = 1'b1;
                push_entry.hdr  = sio_niu_data;
                push_entry.perr = {4'b0, par_err};
            end
        end else if (state_q == PAYLOAD && beat_cnt_q == 2'd3) begin
            state_d             = IDLE;
            push                = 1'b1;
            push_entry.hdr      = hdr_q;
            push_entry.data     = {sio_niu_data, data_q};
            push_entry.has_data = 1'b1;
            push_entry.perr     = {par_err, beat_perr_q, hdr_perr_q};
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            hdr_q       <= '0;
            hdr_perr_q  <= 1'b0;
            data_q      <= '0;
            beat_perr_q <= '0;
            ovf_err     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovf_err   <= ovf_err | fifo_ovf;
            proto_err <= proto_err | proto_set;
            if (sio_niu_hdr_vld) begin
                hdr_q      <= sio_niu_data;
                hdr_perr_q <= par_err;
                beat_cnt_q <= '0;
            end else if (state_q == PAYLOAD) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                // Beat 3 bypasses this buffer straight into the FIFO entry.
                if (beat_cnt_q != 2'd3) begin
                    data_q[{beat_cnt_q, 7'd0} +: BEAT_W] <= sio_niu_data;
                    beat_perr_q[beat_cnt_q]              <= par_err;
                end
            end
        end
    end

    niu_sio_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iol2clk    (iol2clk),
        .rst_l      (rst_l),
        .push       (push),
        .push_entry (push_entry),
        .pop        (rsp_vld & rsp_rdy),
        .head       (head),
        .vld        (rsp_vld),
        .full       (fifo_full),
        .ovf        (fifo_ovf)
    );

    assign rsp_hdr      = head.hdr;
    assign rsp_data     = head.data;
    assign rsp_has_data = head.has_data;
    assign rsp_perr     = head.perr;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_niu_sio_rsp_rcv.sv
// Scoreboard bench for niu_sio_rsp_rcv: a packet-level reference model predicts queue contents,
// a negedge monitor compares every presented head and the sticky error flags.
module tb_niu_sio_rsp_rcv;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [127:0] hdr;
        logic [511:0] data;
        logic         has_data;
        logic [4:0]   perr;
    } exp_t;

    logic         iol2clk = 1'b0;
    logic         rst_l   = 1'b0;
    logic         hdr_vld = 1'b0;
    logic         datareq = 1'b0;
    logic [127:0] data    = '0;
    logic [7:0]   parity  = '0;
    logic         rsp_rdy = 1'b0;
    logic         rsp_vld;
    logic [127:0] rsp_hdr;
    logic [511:0] rsp_data;
    logic         rsp_has_data;
    logic [4:0]   rsp_perr;
    logic         ovf_err;
    logic         proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    always #5 iol2clk = ~iol2clk;

    niu_sio_rsp_rcv #(.DEPTH(DEPTH)) dut (
        .iol2clk         (iol2clk),
        .rst_l           (rst_l),
        .sio_niu_hdr_vld (hdr_vld),
        .sio_niu_datareq (datareq),
        .sio_niu_data    (data),
        .sio_niu_parity  (parity),
        .rsp_vld         (rsp_vld),
        .rsp_rdy         (rsp_rdy),
        .rsp_hdr         (rsp_hdr),
        .rsp_data        (rsp_data),
        .rsp_has_data    (rsp_has_data),
        .rsp_perr        (rsp_perr),
        .ovf_err         (ovf_err),
        .proto_err       (proto_err)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic logic lane_err(input logic [127:0] d, input logic [7:0] p);
`ifdef NIU_SIO_RCV_PAR_CHK_EN
        return good_par(d) != p;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- reference model ----------------
    exp_t         exp_q[$];
    logic [127:0] m_hdr;
    logic [127:0] m_beats[4];
    logic [4:0]   m_perr;
    int           m_beat;
    bit           m_inpay;
    int           m_cnt;
    bit           m_ovf;
    bit           m_proto;

    always @(posedge iol2clk or negedge rst_l) begin
        bit   pop;
        bit   fin;
        exp_t e;
        if (!rst_l) begin
            exp_q.delete();
            m_inpay = 0; m_beat = 0; m_cnt = 0; m_ovf = 0; m_proto = 0; m_perr = '0; m_hdr = '0;
        end else begin
            pop = (m_cnt > 0) && rsp_rdy;
            fin = 0;
            e   = '0;
            if (hdr_vld) begin
                if (m_inpay) m_proto = 1;
                m_hdr  = data;
                m_perr = {4'b0, lane_err(data, parity)};
                if (datareq) begin
                    m_inpay = 1;
                    m_beat  = 0;
                end else begin
                    m_inpay = 0;
                    fin     = 1;
                    e.hdr   = data;
                    e.perr  = m_perr;
                end
            end else if (m_inpay) begin
                m_beats[m_beat]  = data;
                m_perr[m_beat+1] = lane_err(data, parity);
                m_beat++;
                if (m_beat == 4) begin
                    m_inpay    = 0;
                    fin        = 1;
                    e.hdr      = m_hdr;
                    e.data     = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
                    e.has_data = 1;
                    e.perr     = m_perr;
                end
            end
            if (fin) begin
                if (m_cnt - int'(pop) < DEPTH) begin
                    exp_q.push_back(e);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) m_cnt--;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge iol2clk) begin
        if (!rst_l) begin
            check("reset_vld", rsp_vld, 0);
            check("reset_hdr", rsp_hdr, 0);
            check("reset_data", rsp_data, 0);
            check("reset_flags", {rsp_has_data, rsp_perr, ovf_err, proto_err}, 0);
        end else begin
            check("rsp_vld", rsp_vld, m_cnt > 0);
            check("ovf_err", ovf_err, m_ovf);
            check("proto_err", proto_err, m_proto);
            if (rsp_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_vld, 0);
                end else begin
                    check("rsp_hdr", rsp_hdr, exp_q[0].hdr);
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_has_data", rsp_has_data, exp_q[0].has_data);
                    check("rsp_perr", rsp_perr, exp_q[0].perr);
                    if (rsp_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic hv, input logic dr, input logic [127:0] d, input logic [7:0] p);
        @(posedge iol2clk);
        #2;
        hdr_vld = hv;
        datareq = dr;
        data    = d;
        parity  = p;
        rsp_rdy = (rdy_mode == 2) ? 1'($urandom_range(1)) : 1'(rdy_mode);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd128();
            drive(0, 0, d, good_par(d));
        end
    endtask

    task automatic send_ack(input logic [127:0] h, input logic [7:0] flip);
        drive(1, 0, h, good_par(h) ^ flip);
    endtask

    // nbeats < 4 leaves the packet unfinished for protocol-violation tests.
    task automatic send_data(input logic [127:0] h, input logic [511:0] pl,
                             input logic [39:0] flip, input int nbeats);
        logic [127:0] b;
        drive(1, 1, h, good_par(h) ^ flip[7:0]);
        for (int i = 0; i < nbeats; i++) begin
            b = pl[128*i +: 128];
            drive(0, 0, b, good_par(b) ^ flip[8*(i+1) +: 8]);
        end
    endtask

    initial begin
        logic [127:0] h;
        logic [511:0] pl;
        logic [39:0]  fl;
        int           kind;

        pl = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
        repeat (3) @(posedge iol2clk);
        #2 rst_l = 1'b1;

        rdy_mode = 1;
        send_ack({{30{4'h0}}, 8'hA5}, 8'h00);
        idle(3);
        send_data({{30{4'h0}}, 8'h5A}, pl, 40'h0, 4);
        idle(3);
        // parity lane 3 flipped on beat 2
        send_data({{30{4'h0}}, 8'h77}, pl, {8'h00, 8'h08, 8'h00, 8'h00, 8'h00}, 4);
        idle(3);

        rdy_mode = 0;
        send_ack(128'h1, 8'h00);
        send_ack(128'h2, 8'h00);
        send_ack(128'h3, 8'h00);
        idle(3);
        rdy_mode = 1;
        idle(4);

        send_data(128'hB1, pl, 40'h0, 1);
        send_data(128'hB2, ~pl, 40'h0, 4);
        idle(3);

        rdy_mode = 0;
        send_ack(128'hC0, 8'h00);
        send_data(128'hC1, pl, 40'h0, 2);
        @(posedge iol2clk);
        #2 rst_l = 1'b0;
        hdr_vld = 1'b0;
        repeat (2) @(posedge iol2clk);
        #2 rst_l = 1'b1;
        rdy_mode = 1;
        send_ack(128'hC2, 8'h00);
        idle(3);

        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(9);
            h    = rnd128();
            pl   = {rnd128(), rnd128(), rnd128(), rnd128()};
            fl   = ($urandom_range(3) == 0) ? (40'h1 << $urandom_range(39)) : 40'h0;
            if (kind < 4)      send_ack(h, fl[7:0]);
            else if (kind < 9) send_data(h, pl, fl, 4);
            else               send_data(h, pl, fl, $urandom_range(3));
            idle($urandom_range(2));
        end

        rdy_mode = 1;
        idle(1);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check("drained", exp_q.size(), 0);
        idle(2);
        check("final_vld", rsp_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
